// File: rtl/am_pkg.sv
// Shared definitions for the AM demodulator post-filter path.
//   AM_SAMPLE_W : width of the signed FIR output sample (16)
//   clog2       : ceiling log2, used to derive shift amounts from DECIM
//   sat_signed  : clamp a signed value into a signed field of 'width' bits
package am_pkg;

    localparam int AM_SAMPLE_W = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/am_dc_tracker.sv
// DC removal stage: averages a decimated block sum and subtracts a
// leaky-integrator estimate of the carrier-induced DC level.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   snap         : signed block sum (AM_SAMPLE_W + AVG_SHIFT bits)
//   snap_valid   : one-cycle strobe qualifying snap
//   diff         : signed 17-bit DC-free sample, registered
//   diff_valid   : one-cycle strobe qualifying diff
module am_dc_tracker
    import am_pkg::*;
#(
    parameter int AVG_SHIFT = 3,
    parameter int DC_SHIFT  = 6
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic signed [AM_SAMPLE_W+AVG_SHIFT-1:0]  snap,
    input  logic                                     snap_valid,
    output logic signed [AM_SAMPLE_W:0]              diff,
    output logic                                     diff_valid
);

    localparam int SNAP_W = AM_SAMPLE_W + AVG_SHIFT;
    localparam int DIFF_W = AM_SAMPLE_W + 1;
    // One guard bit above the 16+DC_SHIFT range keeps the integrator from
    // wrapping for any sequence of 16-bit averages.
    localparam int DC_W   = AM_SAMPLE_W + DC_SHIFT + 1;

    logic signed [DC_W-1:0]   dc_acc;
    logic signed [DIFF_W-1:0] avg;
    logic signed [DIFF_W-1:0] dc_int;
    logic signed [DIFF_W-1:0] diff_next;
    logic signed [DC_W-1:0]   diff_ext;
    logic                     unused_snap_frac;

    // Dropping the low AVG_SHIFT bits of a two's-complement sum is an
    // arithmetic shift with floor rounding; the top bit is repeated to
    // widen the 16-bit average to the 17-bit difference domain.
    assign avg              = {snap[SNAP_W-1], snap[SNAP_W-1:AVG_SHIFT]};
    assign unused_snap_frac = ^snap[AVG_SHIFT-1:0];
    assign dc_int           = dc_acc[DC_W-1:DC_SHIFT];
    assign diff_next        = avg - dc_int;
    assign diff_ext         = {{DC_SHIFT{diff_next[DIFF_W-1]}}, diff_next};

    // ---- stage B: snap -> diff ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_acc     <= '0;
            diff       <= '0;
            diff_valid <= 1'b0;
        end else begin
            diff_valid <= snap_valid;
            if (snap_valid) begin
                diff   <= diff_next;
                dc_acc <= dc_acc + diff_ext;
            end
        end
    end

endmodule

// File: rtl/am_decim_dcblock.sv
// AM demodulator post-filter: integrate-and-dump decimation by DECIM,
// leaky-integrator DC removal, scaling and saturation to OUT_W bits,
// presented through a single valid/ready holding register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_data      : signed 16-bit FIR output sample
//   in_valid     : one-cycle strobe per FIR sample (no backpressure)
//   out_data     : signed OUT_W-bit audio sample (holding register)
//   out_valid    : holding register full
//   out_ready    : downstream accepts when high together with out_valid
//   overflow     : sticky, set when any result was clamped
//   sample_drop  : one-cycle pulse when a result found the register busy
module am_decim_dcblock
    import am_pkg::*;
#(
    parameter int DECIM    = 8,
    parameter int DC_SHIFT = 6,
    parameter int OUT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [AM_SAMPLE_W-1:0] in_data,
    input  logic                          in_valid,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic                          sample_drop
);

    localparam int LOG2D  = clog2(DECIM);
    localparam int ACC_W  = AM_SAMPLE_W + LOG2D;
    localparam int DIFF_W = AM_SAMPLE_W + 1;

    if (DECIM < 2 || DECIM > 64 || (1 << LOG2D) != DECIM) begin : g_bad_decim
        $error("am_decim_dcblock: DECIM must be a power of two in 2..64");
    end
    if (OUT_W < 4 || OUT_W > AM_SAMPLE_W) begin : g_bad_out_w
        $error("am_decim_dcblock: OUT_W must be in 4..16");
    end

    logic signed [ACC_W-1:0]  acc;
    logic [LOG2D-1:0]         cnt;
    logic signed [ACC_W-1:0]  in_ext;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  snap_p0;
    logic                     vld_p0;
    logic signed [DIFF_W-1:0] diff_p1;
    logic                     vld_p1;
    logic signed [31:0]       scaled;
    logic signed [31:0]       sat_full;
    logic                     clamped;
    logic                     load;
    logic                     unused_sat_hi;

    assign in_ext   = {{LOG2D{in_data[AM_SAMPLE_W-1]}}, in_data};
    assign acc_next = acc + in_ext;

    // ---- stage A: integrate and dump ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            snap_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (in_valid) begin
                // DECIM is a power of two, so the last sample of a block
                // is the one seen with every count bit set.
                if (&cnt) begin
                    snap_p0 <= acc_next;
                    vld_p0  <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + LOG2D'(1);
                end
            end
        end
    end

    // ---- stage B: DC removal ----
    am_dc_tracker #(
        .AVG_SHIFT (LOG2D),
        .DC_SHIFT  (DC_SHIFT)
    ) u_dc_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .snap       (snap_p0),
        .snap_valid (vld_p0),
        .diff       (diff_p1),
        .diff_valid (vld_p1)
    );

    assign scaled        = 32'(diff_p1) >>> (AM_SAMPLE_W - OUT_W);
    assign sat_full      = sat_signed(scaled, OUT_W);
    assign clamped       = (sat_full != scaled);
    assign unused_sat_hi = ^sat_full[31:OUT_W];

    // A new result may enter the holding register if it is empty or is
    // being emptied by a transfer in this very cycle.
    assign load = vld_p1 && (!out_valid || out_ready);

    // ---- stage C: scale, saturate, hold ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
            sample_drop <= 1'b0;
        end else begin
            sample_drop <= vld_p1 && out_valid && !out_ready;
            if (load) begin
                out_data  <= sat_full[OUT_W-1:0];
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (vld_p1 && clamped) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_am_decim_dcblock.sv
// Directed testbench for am_decim_dcblock (DECIM=8, DC_SHIFT=6, OUT_W=8).
module tb_am_decim_dcblock;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [15:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              overflow;
    logic              sample_drop;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int drops = 0;
    int q[$];
    int qt[$];

    always #5 clk = ~clk;

    am_decim_dcblock #(.DECIM(8), .DC_SHIFT(6), .OUT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .sample_drop (sample_drop)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted transfer and every drop pulse.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q.push_back(int'(out_data));
            qt.push_back(cyc);
        end
        if (sample_drop) drops = drops + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed_block(input int v);
        for (int i = 0; i < 8; i++) begin
            in_data  = 16'(v);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        q.delete();
        qt.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        nvec++; if (out_data !== 8'sd0) begin nerr++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset_overflow got %b want 0", overflow); end
        nvec++; if (sample_drop !== 1'b0) begin nerr++; $display("FAIL reset_sample_drop got %b want 0", sample_drop); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_average;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data  = 16'(i * 256);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL avg_valid_after_e0 got %b want 0", out_valid); end
        tick(1);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL avg_valid_after_e1 got %b want 0", out_valid); end
        tick(1);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL avg_valid_after_e2 got %b want 1", out_valid); end
        nvec++; if (out_data !== 8'sd3) begin nerr++; $display("FAIL avg_data got %0d want 3", out_data); end
        tick(1);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL avg_valid_after_xfer got %b want 0", out_valid); end
        nvec++; if (q.size() !== 1) begin nerr++; $display("FAIL avg_xfer_count got %0d want 1", q.size()); end
    endtask

    task automatic test_dc_convergence;
        int bad;
        int nz;
        do_reset();
        out_ready = 1'b1;
        repeat (200) feed_block(1000);
        tick(4);
        nvec++; if (q.size() !== 200) begin nerr++; $display("FAIL dc_count got %0d want 200", q.size()); end
        if (q.size() > 0) begin
            nvec++; if (q[0] !== 3) begin nerr++; $display("FAIL dc_first got %0d want 3", q[0]); end
            bad = 0;
            for (int i = 1; i < q.size(); i++) if (q[i] > q[i-1]) bad++;
            nvec++; if (bad !== 0) begin nerr++; $display("FAIL dc_monotonic got %0d rises want 0", bad); end
            nz = 0;
            for (int i = (q.size() > 20 ? q.size() - 20 : 0); i < q.size(); i++) if (q[i] != 0) nz++;
            nvec++; if (nz !== 0) begin nerr++; $display("FAIL dc_settled got %0d nonzero want 0", nz); end
        end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL dc_overflow got %b want 0", overflow); end
    endtask

    task automatic test_saturation;
        do_reset();
        out_ready = 1'b1;
        repeat (1000) feed_block(-32768);
        tick(4);
        nvec++; if (q.size() == 0 || q[0] !== -128) begin nerr++; $display("FAIL sat_neg_first got %0d want -128", q.size() ? q[0] : 999); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL sat_neg_no_ovf got %b want 0", overflow); end
        q.delete();
        feed_block(32767);
        tick(3);
        nvec++; if (q.size() == 0 || q[0] !== 127) begin nerr++; $display("FAIL sat_step_up got %0d want 127", q.size() ? q[0] : 999); end
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL sat_step_up_ovf got %b want 1", overflow); end
        feed_block(0);
        tick(3);
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL sat_sticky got %b want 1", overflow); end

        do_reset();
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL sat_ovf_reset got %b want 0", overflow); end
        repeat (1000) feed_block(32767);
        tick(4);
        nvec++; if (q.size() == 0 || q[0] !== 127) begin nerr++; $display("FAIL sat_pos_first got %0d want 127", q.size() ? q[0] : 999); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL sat_pos_no_ovf got %b want 0", overflow); end
        q.delete();
        feed_block(-32768);
        tick(3);
        nvec++; if (q.size() == 0 || q[0] !== -128) begin nerr++; $display("FAIL sat_step_down got %0d want -128", q.size() ? q[0] : 999); end
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL sat_step_down_ovf got %b want 1", overflow); end
    endtask

    task automatic test_backpressure;
        int d0;
        // Held first result, second one dropped.
        do_reset();
        out_ready = 1'b0;
        d0 = drops;
        feed_block(256);
        tick(2);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_held_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 8'sd1) begin nerr++; $display("FAIL bp_held_data got %0d want 1", out_data); end
        feed_block(1024);
        tick(2);
        nvec++; if (sample_drop !== 1'b1) begin nerr++; $display("FAIL bp_drop_pulse got %b want 1", sample_drop); end
        nvec++; if (out_data !== 8'sd1) begin nerr++; $display("FAIL bp_data_stable got %0d want 1", out_data); end
        tick(1);
        nvec++; if (sample_drop !== 1'b0) begin nerr++; $display("FAIL bp_drop_width got %b want 0", sample_drop); end
        nvec++; if (drops - d0 !== 1) begin nerr++; $display("FAIL bp_drop_count got %0d want 1", drops - d0); end
        out_ready = 1'b1;
        tick(1);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_valid_fall got %b want 0", out_valid); end
        nvec++; if (q.size() !== 1 || q[0] !== 1) begin nerr++; $display("FAIL bp_xfer got %0d items first %0d want 1 item 1", q.size(), q.size() ? q[0] : 999); end

        // Ready in the load cycle: new result replaces the outgoing one.
        do_reset();
        out_ready = 1'b0;
        d0 = drops;
        feed_block(256);
        tick(2);
        feed_block(1024);
        tick(1);
        out_ready = 1'b1;
        tick(1);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL bp_swap_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 8'sd3) begin nerr++; $display("FAIL bp_swap_data got %0d want 3", out_data); end
        nvec++; if (sample_drop !== 1'b0) begin nerr++; $display("FAIL bp_swap_drop got %b want 0", sample_drop); end
        tick(1);
        nvec++; if (q.size() !== 2) begin nerr++; $display("FAIL bp_swap_count got %0d want 2", q.size()); end
        else begin
            nvec++; if (q[0] !== 1 || q[1] !== 3) begin nerr++; $display("FAIL bp_swap_order got %0d,%0d want 1,3", q[0], q[1]); end
        end
        nvec++; if (drops - d0 !== 0) begin nerr++; $display("FAIL bp_swap_drops got %0d want 0", drops - d0); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        out_ready = 1'b1;
        feed_block(-32768);
        feed_block(32767);
        tick(3);
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL mid_pre_ovf got %b want 1", overflow); end
        out_ready = 1'b0;
        feed_block(0);
        tick(2);
        nvec++; if (out_valid !== 1'b1 || out_data !== -8'sd1) begin nerr++; $display("FAIL mid_pre_hold got v=%b d=%0d want v=1 d=-1", out_valid, out_data); end
        for (int i = 0; i < 5; i++) begin
            in_data  = 16'sd1000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        nvec++; if (out_data !== 8'sd0) begin nerr++; $display("FAIL mid_rst_data got %0d want 0", out_data); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL mid_rst_ovf got %b want 0", overflow); end
        nvec++; if (sample_drop !== 1'b0) begin nerr++; $display("FAIL mid_rst_drop got %b want 0", sample_drop); end
        @(posedge clk);
        #1;
        tick(1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(1);
        feed_block(256);
        tick(2);
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL mid_after_valid got %b want 1", out_valid); end
        nvec++; if (out_data !== 8'sd1) begin nerr++; $display("FAIL mid_after_data got %0d want 1", out_data); end
    endtask

    task automatic test_back_to_back;
        int d0;
        int bad;
        do_reset();
        out_ready = 1'b1;
        d0 = drops;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = 16'(i * 100);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        tick(4);
        nvec++; if (q.size() !== 8) begin nerr++; $display("FAIL b2b_count got %0d want 8", q.size()); end
        bad = 0;
        for (int i = 1; i < qt.size(); i++) if (qt[i] - qt[i-1] != 8) bad++;
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL b2b_spacing got %0d bad gaps want 0", bad); end
        nvec++; if (drops - d0 !== 0) begin nerr++; $display("FAIL b2b_drops got %0d want 0", drops - d0); end
    endtask

    initial begin
        test_reset();
        test_average();
        test_dc_convergence();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
